// File: rtl/mips_debug_ctrl.sv
// rtl/mips_debug_ctrl.sv - run-control, PC breakpoints and register/memory dump for the single-cycle MIPS
module mips_debug_ctrl #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int MEM_AW     = 6,
    parameter int NUM_BP     = 2,
    parameter bit RESET_HALT = 1'b0
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic [DATA_W-1:0]        PC,
    output logic                     CpuEn,
    input  logic                     Halt_req,
    input  logic                     Run_req,
    input  logic                     Step_req,
    input  logic [NUM_BP-1:0]        BpEn,
    input  logic [NUM_BP*DATA_W-1:0] BpAddr,
    output logic [NUM_BP-1:0]        BpHit,
    output logic                     Halted,
    output logic [31:0]              InstrCount,
    input  logic                     DumpStart,
    input  logic                     DumpSel,
    input  logic [MEM_AW-1:0]        DumpBase,
    input  logic [MEM_AW:0]          DumpCount,
    output logic [REG_AW-1:0]        ReadReg,
    input  logic [DATA_W-1:0]        RegData,
    output logic [MEM_AW-1:0]        ReadMem,
    input  logic [DATA_W-1:0]        MemData,
    output logic                     DumpValid,
    output logic [DATA_W-1:0]        DumpData,
    output logic [MEM_AW-1:0]        DumpIdx,
    input  logic                     DumpReady,
    output logic                     DumpDone
);

    typedef enum logic [2:0] {S_RUN, S_HALTED, S_STEP, S_RESUME, S_DUMP} state_t;

    localparam state_t RESET_STATE = RESET_HALT ? S_HALTED : S_RUN;
    // Register dumps wrap inside the 2^REG_AW register file.
    localparam logic [MEM_AW-1:0] REG_MASK = MEM_AW'((64'd1 << REG_AW) - 64'd1);

    state_t              state, state_next;
    logic [NUM_BP-1:0]   bp_vec, bp_hit;
    logic                bp_match, set_hit, leave_halted, dump_enter, load_beat, dump_done;
    logic [31:0]         instr_count;
    logic                sel, dump_valid;
    logic [MEM_AW-1:0]   idx, idx_inc, dump_idx;
    logic [MEM_AW:0]     rem;
    logic [DATA_W-1:0]   dump_data;

    always_comb begin
        bp_vec = '0;
        for (int i = 0; i < NUM_BP; i++)
            bp_vec[i] = BpEn[i] && (PC == BpAddr[i*DATA_W +: DATA_W]);
    end
    assign bp_match = |bp_vec;
    assign idx_inc  = sel ? (idx + MEM_AW'(1)) : ((idx + MEM_AW'(1)) & REG_MASK);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= RESET_STATE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        CpuEn        = 1'b0;
        set_hit      = 1'b0;
        leave_halted = 1'b0;
        dump_enter   = 1'b0;
        load_beat    = 1'b0;
        dump_done    = 1'b0;
        case (state)
            S_RUN: begin
                if (Halt_req || bp_match) begin
                    state_next = S_HALTED;
                    set_hit    = bp_match;
                end else begin
                    CpuEn = 1'b1;
                end
            end
            S_HALTED: begin
                leave_halted = DumpStart || Step_req || Run_req;
                if (DumpStart) begin
                    state_next = S_DUMP;
                    dump_enter = 1'b1;
                end else if (Step_req) begin
                    state_next = S_STEP;
                end else if (Run_req) begin
                    state_next = S_RESUME;
                end
            end
            S_STEP: begin
                CpuEn      = 1'b1;
                state_next = S_HALTED;
            end
            S_RESUME: begin
                CpuEn      = 1'b1;
                state_next = S_RUN;
            end
            S_DUMP: begin
                // Output slot is free either because nothing is pending or the pending beat leaves now.
                if (!dump_valid || DumpReady) begin
                    if (rem != '0) begin
                        load_beat = 1'b1;
                    end else begin
                        dump_done  = 1'b1;
                        state_next = S_HALTED;
                    end
                end
            end
            default: state_next = RESET_STATE;
        endcase
        if (Reset) begin
            CpuEn     = 1'b0;
            dump_done = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            bp_hit      <= '0;
            instr_count <= '0;
            sel         <= 1'b0;
            idx         <= '0;
            rem         <= '0;
            dump_valid  <= 1'b0;
            dump_data   <= '0;
            dump_idx    <= '0;
        end else begin
            if (CpuEn) instr_count <= instr_count + 32'd1;
            if (leave_halted)  bp_hit <= '0;
            else if (set_hit)  bp_hit <= bp_hit | bp_vec;
            if (dump_enter) begin
                sel <= DumpSel;
                idx <= DumpSel ? DumpBase : (DumpBase & REG_MASK);
                rem <= DumpCount;
            end
            if (load_beat) begin
                dump_data  <= sel ? MemData : RegData;
                dump_idx   <= idx;
                dump_valid <= 1'b1;
                idx        <= idx_inc;
                rem        <= rem - (MEM_AW+1)'(1);
            end else if (dump_valid && DumpReady) begin
                dump_valid <= 1'b0;
            end
        end
    end

    assign BpHit      = bp_hit;
    assign Halted     = (state == S_HALTED) || (state == S_DUMP);
    assign InstrCount = instr_count;
    assign ReadReg    = idx[REG_AW-1:0];
    assign ReadMem    = idx;
    assign DumpValid  = dump_valid;
    assign DumpData   = dump_data;
    assign DumpIdx    = dump_idx;
    assign DumpDone   = dump_done;

endmodule
